// File: rtl/ddr_rx_gearbox.sv
// ddr_rx_gearbox: multi-lane DDR deserializer with per-lane bitslip and pattern-training alignment
module ddr_rx_gearbox #(
  parameter int LANES = 4,
  parameter int RATIO = 8,
  parameter DDR_ALIGNMENT = "C0",
  parameter logic [15:0] TRAIN_PATTERN = 16'h00A5,
  parameter int LOCK_COUNT = 4,
  parameter int SLIP_WAIT = 2
) (
  input  logic                   C,
  input  logic                   R,
  input  logic                   CE,
  input  logic [LANES-1:0]       D_RISE,
  input  logic [LANES-1:0]       D_FALL,
  input  logic                   TRAIN,
  input  logic [LANES-1:0]       BITSLIP,
  output logic [LANES*RATIO-1:0] Q,
  output logic                   Q_VALID,
  output logic [LANES-1:0]       LOCKED,
  output logic                   ALL_LOCKED,
  output logic [LANES-1:0]       FAIL
);
  localparam int HW = 2 * RATIO;
  localparam int OW = $clog2(RATIO);
  localparam int PW = $clog2(RATIO / 2);
  localparam logic [OW-1:0] OMAX = OW'(RATIO - 1);
  localparam logic [PW-1:0] PMAX = PW'(RATIO / 2 - 1);
  localparam logic [3:0] MMAX = 4'(LOCK_COUNT - 1);
  localparam logic [2:0] WMAX = 3'(SLIP_WAIT - 1);
  localparam logic [RATIO-1:0] PAT = TRAIN_PATTERN[RATIO-1:0];
  localparam bit FALL_FIRST = (DDR_ALIGNMENT == "C1");
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WAIT, S_LOCK} state_t;
  logic [HW-1:0]                 r_hist  [LANES];
  logic [OW-1:0]                 r_off   [LANES];
  logic [OW-1:0]                 r_slips [LANES];
  logic [3:0]                    r_match [LANES];
  logic [2:0]                    r_wait  [LANES];
  state_t                        r_state [LANES];
  logic [PW-1:0]                 r_phase;
  logic                          r_train_d;
  logic                          r_valid;
  logic [LANES-1:0][RATIO-1:0]   r_q;
  logic [LANES-1:0]              r_locked;
  logic [LANES-1:0]              r_fail;
  logic [HW-1:0]                 w_hist  [LANES];
  logic [RATIO-1:0]              w_word  [LANES];
  logic                          w_strobe;
  logic                          w_rise;
  logic                          w_fall;
  function automatic logic [OW-1:0] f_inc(input logic [OW-1:0] v);
    return (v == OMAX) ? '0 : v + 1'b1;
  endfunction
  // w_word is the word as it will look after this cycle's shift, seen through the current offset
  always_comb begin
    w_strobe = CE && (r_phase == PMAX);
    w_rise   = TRAIN && !r_train_d;
    w_fall   = !TRAIN && r_train_d;
    for (int n = 0; n < LANES; n++) begin
      w_hist[n] = {r_hist[n][HW-3:0], FALL_FIRST ? {D_FALL[n], D_RISE[n]} : {D_RISE[n], D_FALL[n]}};
      w_word[n] = w_hist[n][r_off[n] +: RATIO];
    end
  end
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_phase   <= '0;
      r_train_d <= 1'b0;
      r_valid   <= 1'b0;
      r_q       <= '0;
      r_locked  <= '0;
      r_fail    <= '0;
      for (int n = 0; n < LANES; n++) begin
        r_hist[n]  <= '0;
        r_off[n]   <= '0;
        r_slips[n] <= '0;
        r_match[n] <= '0;
        r_wait[n]  <= '0;
        r_state[n] <= S_IDLE;
      end
    end else begin
      r_train_d <= TRAIN;
      r_valid   <= w_strobe;
      if (CE) r_phase <= w_strobe ? '0 : r_phase + 1'b1;
      for (int n = 0; n < LANES; n++) begin
        if (CE) r_hist[n] <= w_hist[n];
        if (w_strobe) r_q[n] <= w_word[n];
        if (w_rise) begin
          r_state[n]  <= S_SEARCH;
          r_locked[n] <= 1'b0;
          r_fail[n]   <= 1'b0;
          r_match[n]  <= '0;
          r_slips[n]  <= '0;
          r_wait[n]   <= '0;
        end else if (w_fall) begin
          r_state[n] <= S_IDLE;
        end else if (!TRAIN) begin
          r_off[n] <= BITSLIP[n] ? f_inc(r_off[n]) : r_off[n];
        end else if (w_strobe) begin
          case (r_state[n])
            S_SEARCH: begin
              if (w_word[n] == PAT) begin
                r_match[n] <= r_match[n] + 1'b1;
                if (r_match[n] == MMAX) begin
                  r_state[n]  <= S_LOCK;
                  r_locked[n] <= 1'b1;
                end
              end else begin
                r_match[n] <= '0;
                r_off[n]   <= f_inc(r_off[n]);
                r_slips[n] <= f_inc(r_slips[n]);
                r_wait[n]  <= '0;
                r_state[n] <= (SLIP_WAIT == 0) ? S_SEARCH : S_WAIT;
                if (r_slips[n] == OMAX) r_fail[n] <= 1'b1;
              end
            end
            S_WAIT: begin
              r_wait[n] <= r_wait[n] + 1'b1;
              if (r_wait[n] == WMAX) r_state[n] <= S_SEARCH;
            end
            default: ;
          endcase
        end
      end
    end
  end
  assign Q          = r_q;
  assign Q_VALID    = r_valid;
  assign LOCKED     = r_locked;
  assign FAIL       = r_fail;
  assign ALL_LOCKED = &r_locked;
endmodule

// File: tb/tb_ddr_rx_gearbox.sv
// tb_ddr_rx_gearbox: table vectors plus hand sequences, words checked through an expected-word queue
module tb_ddr_rx_gearbox;
  logic clk = 1'b0, r = 1'b1, ce = 1'b0, train = 1'b0;
  logic [3:0] d_rise = '0, d_fall = '0, bitslip = '0;
  logic [31:0] q;
  logic q_valid, all_locked;
  logic [3:0] locked, fail;
  logic [7:0] q1;
  logic q_valid1, locked1, all_locked1, fail1;
  int n_cmp = 0, n_bad = 0;
  logic sb_on = 1'b0;
  typedef struct { logic [31:0] q; logic [7:0] q1; logic c1; } exp_t;
  typedef struct { logic [31:0] w; logic [7:0] c1; } vec_t;
  exp_t sb[$];
  exp_t e_pop;
  vec_t tbl[6];
  always #5 clk = ~clk;
  ddr_rx_gearbox dut (
    .C(clk), .R(r), .CE(ce), .D_RISE(d_rise), .D_FALL(d_fall), .TRAIN(train), .BITSLIP(bitslip),
    .Q(q), .Q_VALID(q_valid), .LOCKED(locked), .ALL_LOCKED(all_locked), .FAIL(fail)
  );
  ddr_rx_gearbox #(.LANES(1), .DDR_ALIGNMENT("C1")) dut1 (
    .C(clk), .R(r), .CE(ce), .D_RISE(d_rise[0]), .D_FALL(d_fall[0]), .TRAIN(1'b0), .BITSLIP(1'b0),
    .Q(q1), .Q_VALID(q_valid1), .LOCKED(locked1), .ALL_LOCKED(all_locked1), .FAIL(fail1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // one word per lane, MSB first as (rise,fall) pairs; optional CE-low gap after the second pair
  task automatic send_word(input logic [31:0] w, input logic push, input logic [31:0] e_q,
                           input logic e_c1, input logic [7:0] e_q1, input int gap);
    for (int k = 0; k < 4; k++) begin
      if (k == 2)
        repeat (gap) begin
          ce = 1'b0;
          d_rise = 4'($urandom);
          d_fall = 4'($urandom);
          tick();
        end
      ce = 1'b1;
      for (int n = 0; n < 4; n++) begin
        d_rise[n] = w[n*8 + 7 - 2*k];
        d_fall[n] = w[n*8 + 6 - 2*k];
      end
      if (k == 3 && push) sb.push_back('{q: e_q, q1: e_q1, c1: e_c1});
      tick();
    end
    ce = 1'b0;
  endtask
  task automatic idle(input int cyc, input logic [3:0] bs);
    ce = 1'b0;
    bitslip = bs;
    repeat (cyc) tick();
    bitslip = '0;
  endtask
  task automatic do_reset();
    r = 1'b1;
    #2;
    r = 1'b0;
  endtask
  always @(negedge clk)
    if (sb_on && q_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_q_valid: got q=%h with no word pending", q);
      end else begin
        e_pop = sb.pop_front();
        chk("q", q, e_pop.q);
        if (e_pop.c1) begin
          chk("q_c1", 32'(q1), 32'(e_pop.q1));
          chk("q_valid_c1", 32'(q_valid1), 32'd1);
        end
      end
    end
  initial begin
    tbl[0] = '{w: 32'h123456A5, c1: 8'h5A};
    tbl[1] = '{w: 32'hFF00C381, c1: 8'h42};
    tbl[2] = '{w: 32'h0F1E2D96, c1: 8'h69};
    tbl[3] = '{w: 32'hDEADBE1E, c1: 8'h2D};
    tbl[4] = '{w: 32'h00000000, c1: 8'h00};
    tbl[5] = '{w: 32'hA5A5A5FF, c1: 8'hFF};
    repeat (2) tick();
    chk("rst_q", q, 32'h0);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_fail", 32'(fail), 32'h0);
    chk("rst_all_locked", 32'(all_locked), 32'h0);
    r = 1'b0;
    tick();
    sb_on = 1'b1;
    for (int i = 0; i < 6; i++) send_word(tbl[i].w, 1'b1, tbl[i].w, 1'b1, tbl[i].c1, 0);
    idle(2, 4'h0);
    chk("table_drained", 32'(sb.size()), 32'h0);
    // partial word then asynchronous reset between edges
    sb_on = 1'b0;
    ce = 1'b1;
    d_rise = '1;
    d_fall = '0;
    tick();
    tick();
    ce = 1'b0;
    #2 r = 1'b1;
    #1;
    chk("async_rst_q", q, 32'h0);
    chk("async_rst_q1", 32'(q1), 32'h0);
    chk("async_rst_q_valid", 32'(q_valid), 32'h0);
    chk("async_rst_locked", 32'(locked), 32'h0);
    chk("async_rst_fail", 32'(fail), 32'h0);
    chk("async_rst_all_locked", 32'(all_locked), 32'h0);
    #1 r = 1'b0;
    sb_on = 1'b1;
    send_word(32'h3CC35A96, 1'b1, 32'h3CC35A96, 1'b1, 8'h69, 0);
    idle(3, 4'h0);
    chk("rst_single_valid", 32'(sb.size()), 32'h0);
    // manual bitslip: lane 0 once, then lane 1 held for two cycles
    do_reset();
    send_word(32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b0, 8'h0, 0);
    idle(1, 4'b0001);
    send_word(32'hA5A5A5A5, 1'b1, 32'hA5A5A5D2, 1'b0, 8'h0, 0);
    send_word(32'hA5A5A5A5, 1'b1, 32'hA5A5A5D2, 1'b0, 8'h0, 0);
    idle(2, 4'b0010);
    send_word(32'hA5A5A5A5, 1'b1, 32'hA5A569D2, 1'b0, 8'h0, 0);
    idle(2, 4'h0);
    chk("slip_drained", 32'(sb.size()), 32'h0);
    // CE gating mid-word
    do_reset();
    send_word(32'h3C9681A5, 1'b1, 32'h3C9681A5, 1'b1, 8'h5A, 2);
    idle(3, 4'h0);
    chk("ce_q_hold", q, 32'h3C9681A5);
    chk("ce_drained", 32'(sb.size()), 32'h0);
    // training lock, lane 2 three bits late
    do_reset();
    sb_on = 1'b0;
    train = 1'b1;
    idle(1, 4'h0);
    for (int i = 1; i <= 13; i++) begin
      send_word(32'hA52DA5A5, 1'b0, 32'h0, 1'b0, 8'h0, 0);
      if (i == 4) chk("lock_early_lanes", 32'(locked), 32'hB);
      if (i == 12) begin
        chk("lock_lane2_pending", 32'(locked), 32'hB);
        chk("all_locked_pending", 32'(all_locked), 32'h0);
      end
      if (i == 13) begin
        chk("lock_all_lanes", 32'(locked), 32'hF);
        chk("all_locked_set", 32'(all_locked), 32'h1);
        chk("lock_no_fail", 32'(fail), 32'h0);
      end
    end
    idle(1, 4'hF);
    train = 1'b0;
    idle(1, 4'h0);
    sb_on = 1'b1;
    send_word(32'hA52DA5A5, 1'b1, 32'hA5A5A5A5, 1'b0, 8'h0, 0);
    send_word(32'hA52DA5A5, 1'b1, 32'hA5A5A5A5, 1'b0, 8'h0, 0);
    idle(2, 4'h0);
    chk("train_drained", 32'(sb.size()), 32'h0);
    chk("lock_retained", 32'(locked), 32'hF);
    // training failure on a dead lane
    do_reset();
    sb_on = 1'b0;
    train = 1'b1;
    idle(1, 4'h0);
    for (int i = 1; i <= 22; i++) begin
      send_word(32'hA5A5A500, 1'b0, 32'h0, 1'b0, 8'h0, 0);
      if (i == 21) chk("fail_pending", 32'(fail), 32'h0);
      if (i == 22) begin
        chk("fail_set", 32'(fail), 32'h1);
        chk("fail_locked", 32'(locked), 32'hE);
      end
    end
    train = 1'b0;
    idle(1, 4'h0);
    chk("fail_sticky", 32'(fail), 32'h1);
    train = 1'b1;
    idle(1, 4'h0);
    chk("fail_cleared", 32'(fail), 32'h0);
    chk("locked_cleared", 32'(locked), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ddr_rx_gearbox.md
Name: ddr_rx_gearbox

Overview:
- Multi-lane DDR receive deserializer with per-lane bit alignment.
- Sits directly behind per-lane IDDR2 capture cells: takes one rise bit and one fall bit per lane per clock and assembles RATIO-bit parallel words.
- Per-lane bit offset is set either by manual bitslip or by a training FSM that searches for a known pattern and reports lock.

Parameters:
- LANES, 4, number of DDR data lanes (1..16).
- RATIO, 8, deserialization ratio in bits per word; even, 4..16.
- DDR_ALIGNMENT, "C0", "C0": rise bit is the earlier bit of a pair; "C1": fall bit is the earlier bit.
- TRAIN_PATTERN, 16'h00A5, training word; low RATIO bits used.
- LOCK_COUNT, 4, consecutive matching words needed to declare lock (1..15).
- SLIP_WAIT, 2, words discarded after each training slip (0..7).

Ports:
- C  input  1  clock, rising edge.
- R  input  1  asynchronous active-high reset.
- CE  input  1  capture enable; D_RISE/D_FALL sampled only when high.
- D_RISE  input  LANES  per-lane bit captured on the rising edge (IDDR2 Q0).
- D_FALL  input  LANES  per-lane bit captured on the falling edge (IDDR2 Q1).
- TRAIN  input  1  high: training FSM active on all lanes.
- BITSLIP  input  LANES  manual one-bit slip request per lane; honoured only while TRAIN=0.
- Q  output  LANES*RATIO  lane n word at Q[n*RATIO +: RATIO]; MSB is the oldest bit.
- Q_VALID  output  1  one-cycle strobe marking a new Q.
- LOCKED  output  LANES  per-lane training lock.
- ALL_LOCKED  output  1  AND of LOCKED.
- FAIL  output  LANES  sticky: RATIO slips occurred without lock.

Behaviour:
- Reset (R high, async): shift registers, offsets, phase counter, FSMs, Q, Q_VALID, LOCKED, ALL_LOCKED and FAIL all go to 0. Reset mid-word discards any partial word.
- Bit ordering: per lane, each CE cycle shifts 2 bits into a 2*RATIO-bit history register, newest at the LSB.
  - DDR_ALIGNMENT="C0": D_RISE is shifted in before D_FALL.
  - "C1": D_FALL is shifted in before D_RISE.
- Phase counter: counts 0..RATIO/2-1 on CE cycles and wraps. Word strobe = CE and phase==RATIO/2-1.
- Word output: on the cycle after a strobe, Q lane n = history[offset_n +: RATIO] (value after the strobe shift) and Q_VALID=1.
  - Q holds between strobes.
  - Q_VALID is 0 on every cycle that does not follow a strobe.
- Offset: per lane, 0..RATIO-1. Each slip adds 1, wrapping RATIO-1 to 0.
- Manual slip: BITSLIP[n]=1 with TRAIN=0 increments offset_n in that cycle. The new offset takes effect from the next strobe. A multi-cycle pulse slips once per cycle.
- Training FSM (per lane), evaluated at word strobes only. States:
  - IDLE: entered on reset; exits to SEARCH on a TRAIN rising edge, which clears LOCKED, FAIL, the match count and the slip count.
  - SEARCH:
    - Word == pattern: match count +1. When count reaches LOCK_COUNT, go to LOCKED and set LOCKED[n].
    - Mismatch: count=0, offset+1, slip count+1. Go to WAIT, or stay in SEARCH if SLIP_WAIT=0.
    - Slip count reaching RATIO sets FAIL[n] (sticky). The lane keeps searching and the slip count wraps.
  - WAIT: ignores SLIP_WAIT strobes, then returns to SEARCH.
  - LOCKED: holds the offset. Mismatching words do not drop lock.
- TRAIN falling edge: every lane returns to IDLE. LOCKED and offsets are retained. BITSLIP is ignored while TRAIN=1.
- Simultaneous events:
  - TRAIN rising edge coinciding with a strobe: the FSM enters SEARCH and does not evaluate that word.
  - BITSLIP on the same cycle as a TRAIN rising edge: ignored.
- CE low: history, phase and FSM are frozen, and Q_VALID stays 0.
- Latency: last bit pair presented to Q_VALID is 1 clock.

Test Plan:
- Reset: assert R mid-stream → all outputs 0 immediately, without waiting for a clock edge. After release and 4 CE cycles (RATIO=8), Q_VALID pulses exactly once.
- Ordering: LANES=1, RATIO=8, C0; (rise,fall) pairs (1,0),(1,0),(0,1),(0,1) → Q=8'hA5 one cycle after the 4th pair, Q_VALID=1 for one cycle. With C1 the same input → Q=8'h5A.
- Manual slip: lane 0 stream aligned 8'hA5 at offset 0; pulse BITSLIP[0] one cycle → next words show the bit-shifted value 8'h4B or 8'hD2 per the offset definition, and the value is stable thereafter. Lane 1 is unaffected.
- Training lock: lane 2 misaligned by 3 bits, TRAIN=1, SLIP_WAIT=2, LOCK_COUNT=4 → 3 slips, LOCKED[2]=1 after 4 matching words, ALL_LOCKED rises once the last lane locks.
- Training fail: lane 0 fed constant 0 with TRAIN=1 → FAIL[0] set after 8 slips, LOCKED[0]=0. FAIL clears on the next TRAIN rising edge.
- CE gating / edges: CE toggled 1-0-1 mid-word → word completes after 4 enabled cycles only. BITSLIP asserted while TRAIN=1 → offset unchanged.
